neuron_mac: RTL and testbench

Sequential multiply-accumulate stage for one neuron. It consumes a stream of signed Q8.8 input/weight pairs plus a Q8.8 bias, and accumulates at full precision. It then produces one saturated signed Q8.8 weighted sum per neuron evaluation. It sits directly upstream of the sigmoid activation block: `sum_out` drives the activation input unchanged.

---
 rtl/neuron_mac.sv | 100 ++++++++++
 tb/tb_neuron_mac.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// neuron_mac: multiply-accumulate stage for one neuron.
// Accumulates a stream of signed Q8.8 x*w products plus a Q8.8 bias at full
// precision (Q24.16 in 40 bits), then emits one saturated Q8.8 sum per
// evaluation. The sum is held until the downstream consumer accepts it.
module neuron_mac #(
  parameter int unsigned MAX_TERMS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] bias,
  input  logic [15:0] x_in,
  input  logic [15:0] w_in,
  input  logic        in_last,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] sum_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  localparam int unsigned CNT_W = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUT
  } state_t;

  state_t                state;
  logic signed [39:0]    acc;
  logic [CNT_W-1:0]      term_cnt;

  logic signed [31:0]    prod;
  logic signed [39:0]    acc_next;
  logic signed [39:0]    shifted;
  logic [15:0]           sat_val;
  logic                  final_beat;

  // Product, next accumulator value, and saturated Q8.8 view of it
  always_comb begin
    prod       = $signed(x_in) * $signed(w_in);
    acc_next   = acc + {{8{prod[31]}}, prod};
    shifted    = acc_next >>> 8;
    // In range only when bits 39..15 are a pure sign extension
    if ((&shifted[39:15]) || (~|shifted[39:15])) begin
      sat_val = shifted[15:0];
    end else if (shifted[39]) begin
      sat_val = 16'h8000;
    end else begin
      sat_val = 16'h7FFF;
    end
    final_beat = in_last || (term_cnt == CNT_W'(MAX_TERMS - 1));
  end

  // Handshake flags depend on state only
  assign in_ready = (state == ACCUM);
  assign busy     = (state != IDLE);

  // Evaluation control: load bias, accumulate beats, hold result until taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      term_cnt  <= '0;
      sum_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= {{16{bias[15]}}, bias, 8'h00};
            term_cnt <= '0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc      <= acc_next;
            term_cnt <= term_cnt + CNT_W'(1);
            if (final_beat) begin
              sum_out   <= sat_val;
              out_valid <= 1'b1;
              state     <= OUT;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac: directed steps, expected sums from a
// behavioural model pushed to a queue, popped when out_valid is observed.
module tb_neuron_mac;

  localparam int unsigned MAX_TERMS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] bias;
  logic [15:0] x_in;
  logic [15:0] w_in;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] sum_out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q[$];
  longint      mdl_acc;
  int          mdl_cnt;

  neuron_mac #(.MAX_TERMS(MAX_TERMS)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bias      (bias),
    .x_in      (x_in),
    .w_in      (w_in),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_out   (sum_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sat_q88(input longint v);
    longint s;
    s = v >>> 8;
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; start is seen at the next posedge
  task automatic do_start(input logic [15:0] b);
    start = 1'b1;
    bias  = b;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    mdl_acc = longint'($signed(b)) * 256;
    mdl_cnt = 0;
  endtask

  // One accepted beat; back-to-back calls give one beat per cycle
  task automatic do_beat(input logic [15:0] x, input logic [15:0] w, input logic last);
    check("beat_in_ready", in_ready, 1);
    x_in     = x;
    w_in     = w;
    in_last  = last;
    in_valid = 1'b1;
    mdl_acc  = mdl_acc + longint'($signed(x)) * longint'($signed(w));
    if (last || mdl_cnt == int'(MAX_TERMS) - 1) exp_q.push_back(sat_q88(mdl_acc));
    mdl_cnt++;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
    end
  endtask

  // Expect the result in the cycle right after the final beat
  task automatic expect_out(input string tag);
    int n;
    logic [15:0] e;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 0);
    check({tag, "_valid"}, out_valid, 1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_sum"}, sum_out, e);
    end
  endtask

  // With out_ready high, the handshake completes at the next edge
  task automatic expect_release(input string tag, input logic [15:0] held);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_sum_held"}, sum_out, held);
  endtask

  initial begin
    logic [15:0] held;
    reset     = 1'b1;
    start     = 1'b0;
    bias      = '0;
    x_in      = '0;
    w_in      = '0;
    in_last   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    mdl_acc   = 0;
    mdl_cnt   = 0;

    // Reset state
    stall(3);
    check("rst_sum", sum_out, 16'h0000);
    check("rst_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);

    // in_valid in IDLE is ignored
    in_valid = 1'b1; in_last = 1'b1; x_in = 16'h0100; w_in = 16'h0100;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    check("idle_ignore_busy", busy, 0);
    check("idle_ignore_valid", out_valid, 0);

    // Basic sum: 0.5 + 2.0 - 1.5 = 1.0
    do_start(16'h0080);
    check("basic_in_ready", in_ready, 1);
    check("basic_busy", busy, 1);
    do_beat(16'h0100, 16'h0200, 1'b0);
    do_beat(16'hFF00, 16'h0180, 1'b1);
    check("basic_in_ready_off", in_ready, 0);
    expect_out("basic");
    check("basic_const", sum_out, 16'h0100);
    expect_release("basic", 16'h0100);

    // Positive saturation
    do_start(16'h0000);
    do_beat(16'h7FFF, 16'h7FFF, 1'b0);
    do_beat(16'h7FFF, 16'h7FFF, 1'b0);
    do_beat(16'h7FFF, 16'h7FFF, 1'b1);
    expect_out("sat_pos");
    expect_release("sat_pos", 16'h7FFF);

    // Negative saturation
    do_start(16'h0000);
    do_beat(16'h8000, 16'h0200, 1'b1);
    expect_out("sat_neg");
    expect_release("sat_neg", 16'h8000);

    // Truncation toward -inf
    do_start(16'h0000);
    do_beat(16'h0001, 16'h0080, 1'b1);
    expect_out("trunc_pos");
    expect_release("trunc_pos", 16'h0000);
    do_start(16'h0000);
    do_beat(16'hFFFF, 16'h0080, 1'b1);
    expect_out("trunc_neg");
    expect_release("trunc_neg", 16'hFFFF);

    // Term limit with a 2-cycle stall; in_last during the stall has no effect
    do_start(16'h0000);
    do_beat(16'h0100, 16'h0100, 1'b0);
    do_beat(16'h0100, 16'h0100, 1'b0);
    in_last = 1'b1;
    stall(2);
    in_last = 1'b0;
    check("stall_no_out", out_valid, 0);
    check("stall_in_ready", in_ready, 1);
    do_beat(16'h0100, 16'h0100, 1'b0);
    do_beat(16'h0100, 16'h0100, 1'b0);
    check("limit_in_ready_off", in_ready, 0);
    expect_out("limit");
    expect_release("limit", 16'h0400);

    // Backpressure with ignored start / in_valid during OUT
    out_ready = 1'b0;
    do_start(16'h0000);
    do_beat(16'h0200, 16'h0300, 1'b1);
    expect_out("bp");
    held = sum_out;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        start = 1'b1; in_valid = 1'b1; in_last = 1'b1;
        x_in = 16'h0100; w_in = 16'h0100; bias = 16'h0100;
      end else begin
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      end
      @(negedge clk);
      check("bp_valid_held", out_valid, 1);
      check("bp_sum_held", sum_out, 16'h0600);
      check("bp_in_ready", in_ready, 0);
    end
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    expect_release("bp", held);
    stall(3);
    check("bp_no_extra_out", out_valid, 0);
    check("bp_no_extra_busy", busy, 0);

    // Reset mid-evaluation, then a clean evaluation
    do_start(16'h0300);
    do_beat(16'h0100, 16'h0100, 1'b0);
    do_beat(16'h0100, 16'h0100, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_sum", sum_out, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_start(16'h0100);
    do_beat(16'h0100, 16'h0100, 1'b1);
    expect_out("after_rst");
    expect_release("after_rst", 16'h0200);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
